// File: rtl/m_vram_writer.sv
// m_vram_writer: takes a raster-ordered pixel stream and writes it into the
// canvas SRAM as a SHAPE_WIDTH x SHAPE_HEIGHT rectangle at (base_x, base_y).
// Pixels that fall off the canvas, or that match the colour key when keying
// is enabled, still use up a beat but produce no write strobe.
module m_vram_writer #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int CANVAS_WIDTH  = 64,
  parameter int CANVAS_HEIGHT = 64,
  parameter int SHAPE_WIDTH   = 32,
  parameter int SHAPE_HEIGHT  = 32,
  parameter int USE_KEY       = 0,
  parameter int KEY           = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [10:0]           i_base_x,
  input  logic [10:0]           i_base_y,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_busy,
  output logic                  o_done
);

  // Canvas coordinates are formed one bit wider than the base so that
  // base + offset never wraps back onto the canvas.
  localparam int COORD_W = 12;
  localparam int LIN_W   = 2 * COORD_W;
  localparam int COL_W   = (SHAPE_WIDTH  > 1) ? $clog2(SHAPE_WIDTH)  : 1;
  localparam int ROW_W   = (SHAPE_HEIGHT > 1) ? $clog2(SHAPE_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SHAPE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SHAPE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [10:0]             base_x_reg;
  logic [10:0]             base_y_reg;
  logic [COL_W-1:0]        col_reg;
  logic [ROW_W-1:0]        row_reg;
  logic                    ready_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    mem_write_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_data_reg;

  logic                    accept;
  logic                    last_pixel;
  logic                    clipped;
  logic                    keyed;
  logic                    write_ok;
  logic [COORD_W-1:0]      pix_x;
  logic [COORD_W-1:0]      pix_y;
  logic [LIN_W-1:0]        lin_addr;

  assign accept     = ready_reg & i_valid;
  assign last_pixel = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

  assign pix_x    = COORD_W'(base_x_reg) + COORD_W'(col_reg);
  assign pix_y    = COORD_W'(base_y_reg) + COORD_W'(row_reg);
  assign clipped  = (pix_x >= COORD_W'(CANVAS_WIDTH)) || (pix_y >= COORD_W'(CANVAS_HEIGHT));
  assign keyed    = (USE_KEY != 0) && (i_data == DATA_WIDTH'(KEY));
  assign write_ok = accept & ~clipped & ~keyed;
  assign lin_addr = LIN_W'(pix_y) * LIN_W'(CANVAS_WIDTH) + LIN_W'(pix_x);

  // Blit sequencer: IDLE -> WRITE -> DONE -> IDLE, with status flags
  // registered alongside the state so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      base_x_reg <= '0;
      base_y_reg <= '0;
      col_reg    <= '0;
      row_reg    <= '0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (i_start) begin
            base_x_reg <= i_base_x;
            base_y_reg <= i_base_y;
            col_reg    <= '0;
            row_reg    <= '0;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b1;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          if (i_abort) begin
            // Abort wins over completion; any pixel accepted this cycle is
            // still written by the write-port block.
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (accept) begin
            if (last_pixel) begin
              ready_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (col_reg == COL_LAST) begin
              col_reg <= '0;
              row_reg <= row_reg + ROW_W'(1);
            end else begin
              col_reg <= col_reg + COL_W'(1);
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // SRAM write port: one cycle behind acceptance; address and data only
  // move when a real write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
    end else begin
      mem_write_reg <= write_ok;
      if (write_ok) begin
        mem_addr_reg <= ADDR_WIDTH'(lin_addr);
        mem_data_reg <= i_data;
      end
    end
  end

  assign o_ready     = ready_reg;
  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_mem_write = mem_write_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_data  = mem_data_reg;

endmodule

// File: doc/m_vram_writer.md
Name: m_vram_writer

Overview:
Writer-side companion to the sprite VRAM readers. Accepts a raster-ordered pixel stream over a valid/ready handshake and writes it into a canvas SRAM as a SHAPE_WIDTH x SHAPE_HEIGHT rectangle anchored at (i_base_x, i_base_y). Sits between a sprite source (ROM walker, UART loader) and the sram write port.
- Clips pixels that fall off the canvas.
- Optionally skips a transparent colour key.
- Signals completion with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 12, width of canvas SRAM address
DATA_WIDTH, 8, pixel width
CANVAS_WIDTH, 64, canvas pixels per row (address stride)
CANVAS_HEIGHT, 64, canvas rows
SHAPE_WIDTH, 32, sprite columns per blit
SHAPE_HEIGHT, 32, sprite rows per blit
USE_KEY, 0, 1 = pixels equal to KEY are not written
KEY, 0, transparent colour value

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-high reset
i_start  input  1  begin a blit; sampled only in IDLE
i_abort  input  1  synchronous abort; returns to IDLE, no done pulse
i_base_x  input  11  canvas x of sprite top-left; latched on accepted start
i_base_y  input  11  canvas y of sprite top-left; latched on accepted start
i_valid  input  1  pixel on i_data is valid
i_data  input  DATA_WIDTH  pixel value
o_ready  output  1  block accepts a pixel this cycle
o_mem_write  output  1  SRAM write strobe, to sram i_write
o_mem_addr  output  ADDR_WIDTH  SRAM address, to sram i_addr
o_mem_data  output  DATA_WIDTH  SRAM write data, to sram i_data
o_busy  output  1  high in WRITE and DONE
o_done  output  1  one-cycle pulse when the last pixel has been issued

Behaviour:
- Reset (async, rst=1): state IDLE, col=row=0, all outputs 0. Clearing mid-blit drops the blit; no partial done pulse.
- States:
  - IDLE: o_ready=0, o_busy=0. If i_start, latch bases, clear col/row, go to WRITE. i_abort in IDLE has no effect.
  - WRITE: o_ready=1, o_busy=1. Accept when i_valid&&o_ready.
  - DONE: lasts exactly one cycle. o_done=1, o_ready=0, then go to IDLE. A new start is honoured from IDLE only; a start asserted during DONE or WRITE is ignored.
- Per accepted pixel:
  - x = base_x + col and y = base_y + row, computed at 12 bits (no wrap).
  - Pixel is clipped if x >= CANVAS_WIDTH or y >= CANVAS_HEIGHT.
  - Pixel is keyed if USE_KEY=1 and i_data == KEY.
- Write latency is one cycle. In the cycle after acceptance, o_mem_write = !(clipped || keyed), o_mem_addr = y*CANVAS_WIDTH + x truncated to ADDR_WIDTH, o_mem_data = i_data. When no pixel is accepted, o_mem_write=0. Address and data hold their last value when not writing.
- Counters: col increments per accepted pixel. At col == SHAPE_WIDTH-1, col wraps to 0 and row increments. Clipped and keyed pixels still advance the counters.
- Last pixel (col == SHAPE_WIDTH-1 and row == SHAPE_HEIGHT-1) accepted: go to DONE next cycle. That pixel's write strobe coincides with the o_done cycle.
- i_abort in WRITE: go to IDLE next cycle with no o_done. If the abort cycle also accepts a pixel, that pixel's write is still issued. i_abort has priority over last-pixel completion.
- i_valid low stalls the blit indefinitely; there is no timeout.
- Throughput: one pixel per cycle. Total blit time is SHAPE_WIDTH*SHAPE_HEIGHT accepted beats plus one DONE cycle.

Test Plan:
- Overrides SHAPE_WIDTH=4, SHAPE_HEIGHT=2, defaults otherwise. Start at base (10,5), stream 8 pixels 0x01..0x08 back-to-back -> writes to addresses 330,331,332,333,394,395,396,397 with data 0x01..0x08, each one cycle after acceptance. o_done pulses in the cycle of the 0x08 write, then o_busy=0.
- Same blit with i_valid toggling every other cycle -> identical address/data sequence. o_mem_write only follows accepted beats.
- Base (62,63) -> only (62,63) and (63,63) are written (addresses 4094, 4095). The other 6 pixels produce no strobe. o_done still pulses after the 8th beat.
- USE_KEY=1, KEY=0x00, stream 0x05,0x00,0x07,0x00,... -> only the odd beats write. Counters still advance and the addresses match the unkeyed case.
- i_abort after 3 pixels -> 3 writes, no o_done, IDLE next cycle. A new start at (0,0) then writes from address 0.
- rst asserted mid-blit (after 5 pixels) -> o_ready, o_mem_write, o_busy and o_done go 0 immediately. A start asserted during WRITE is ignored.
